// File: rtl/wb_retire_queue.sv
// Writeback retire queue: a circular buffer of pending register-file writes
// with per-byte youngest-match forwarding toward ID.
module wb_retire_queue #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int PCW   = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PCW-1:0]               in_pc,
    input  logic [DW/8-1:0]              in_be,
    input  logic [AW-1:0]                in_waddr,
    input  logic [DW-1:0]                in_wdata,
    input  logic                         rf_stall,
    output logic [PCW-1:0]               rf_pc,
    output logic [DW/8-1:0]              rf_be,
    output logic [AW-1:0]                rf_waddr,
    output logic [DW-1:0]                rf_wdata,
    output logic                         rf_retire,
    input  logic [AW-1:0]                fwd_raddr,
    output logic [DW/8-1:0]              fwd_be,
    output logic [DW-1:0]                fwd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int BW = DW / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PCW-1:0] pc_q    [DEPTH];
    logic [BW-1:0]  be_q    [DEPTH];
    logic [AW-1:0]  waddr_q [DEPTH];
    logic [DW-1:0]  wdata_q [DEPTH];

    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;

    logic           not_empty;
    logic           enq;
    logic [PW-1:0]  idx;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q < CW'(DEPTH)) && !flush;
    assign enq       = in_valid && in_ready && !rst;
    // A reset cycle never retires, so in-flight entries are simply discarded.
    assign rf_retire = not_empty && !rf_stall && !flush && !rst;
    assign count     = count_q;

    assign rf_pc    = not_empty ? pc_q[head_q]    : '0;
    assign rf_waddr = not_empty ? waddr_q[head_q] : '0;
    assign rf_wdata = not_empty ? wdata_q[head_q] : '0;
    assign rf_be    = (rf_retire && (waddr_q[head_q] != '0)) ? be_q[head_q] : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq)
                tail_d = tail_q + PW'(1);
            if (rf_retire)
                head_d = head_q + PW'(1);
            if (enq && !rf_retire)
                count_d = count_q + CW'(1);
            else if (!enq && rf_retire)
                count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_q[tail_q]    <= in_pc;
            be_q[tail_q]    <= in_be;
            waddr_q[tail_q] <= in_waddr;
            wdata_q[tail_q] <= in_wdata;
        end
    end

    // Walk oldest to youngest so later matches overwrite earlier ones per lane.
    always_comb begin
        fwd_be   = '0;
        fwd_data = '0;
        idx      = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (waddr_q[idx] == fwd_raddr)) begin
                for (int b = 0; b < BW; b++) begin
                    if (be_q[idx][b]) begin
                        fwd_be[b]         = 1'b1;
                        fwd_data[b*8 +: 8] = wdata_q[idx][b*8 +: 8];
                    end
                end
            end
        end
        if (fwd_raddr == '0) begin
            fwd_be   = '0;
            fwd_data = '0;
        end
    end

endmodule
